// File: rtl/pe_shift_accum_pkg.sv
// Shared types for the bit-serial shift-and-accumulate stage.
package pe_shift_accum_pkg;

  localparam int unsigned SHACC_SHTWD = 3;

  // One accepted beat's control word.
  typedef struct packed {
    logic                   fstpix;
    logic                   init;
    logic                   sht;
    logic [SHACC_SHTWD-1:0] sht_num;
    logic                   sub;
    logic                   lstpix;
  } ShAccOp;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_HOLD
  } shacc_state_e;

endpackage

// File: rtl/pe_shift_accum_lane.sv
// One accumulator lane: shift, add/subtract, overflow detect, registered acc.
// Optional saturation when PE_SHACC_SAT_EN is defined.
module pe_shift_accum_lane
  import pe_shift_accum_pkg::*;
#(
  parameter int AUODWD  = 16,
  parameter int PSUMDWD = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   fst_i,
  input  logic                   init_i,
  input  logic                   sht_i,
  input  logic [SHACC_SHTWD-1:0] sht_num_i,
  input  logic                   sub_i,
  input  logic [AUODWD-1:0]      data_i,
  input  logic [PSUMDWD-1:0]     psum_i,
  output logic [PSUMDWD-1:0]     acc_o,
  output logic                   ovf_o
);

  localparam int SHAW = 1 << SHACC_SHTWD;
`ifdef PE_SHACC_SAT_EN
  localparam logic [PSUMDWD-1:0] PMAX = {1'b0, {(PSUMDWD-1){1'b1}}};
  localparam logic [PSUMDWD-1:0] PMIN = {1'b1, {(PSUMDWD-1){1'b0}}};
`endif

  logic signed [PSUMDWD-1:0] acc_q, acc_d;
  logic                      ovf_q, ovf_d;
  logic signed [PSUMDWD-1:0] shifted, base, result;
  logic        [SHAW-1:0]    sh_amt;
  logic                      sh_lost, add_ovf;
  logic signed [PSUMDWD:0]   d_ext, base_ext, sum;

  // Next accumulator value: shift first, then add or subtract the lane value.
  always_comb begin
    sh_amt  = SHAW'(1) << sht_num_i;
    shifted = '0;
    sh_lost = 1'b0;
    if (int'(sh_amt) >= PSUMDWD) begin
      shifted = '0;
      sh_lost = (acc_q != '0);
    end else begin
      shifted = acc_q << sh_amt;
      // Bits were lost if shifting back does not restore the original value.
      sh_lost = ((shifted >>> sh_amt) != acc_q);
    end
`ifdef PE_SHACC_SAT_EN
    if (sh_lost) shifted = acc_q[PSUMDWD-1] ? PMIN : PMAX;
`endif
    if (fst_i)      base = init_i ? psum_i : '0;
    else if (sht_i) base = shifted;
    else            base = acc_q;

    d_ext    = {{(PSUMDWD+1-AUODWD){data_i[AUODWD-1]}}, data_i};
    base_ext = {base[PSUMDWD-1], base};
    sum      = sub_i ? (base_ext - d_ext) : (base_ext + d_ext);
    add_ovf  = sum[PSUMDWD] ^ sum[PSUMDWD-1];
`ifdef PE_SHACC_SAT_EN
    result   = add_ovf ? (sum[PSUMDWD] ? PMIN : PMAX) : sum[PSUMDWD-1:0];
`else
    result   = sum[PSUMDWD-1:0];
`endif

    acc_d = acc_q;
    ovf_d = ovf_q;
    if (en_i) begin
      acc_d = result;
      ovf_d = (fst_i ? 1'b0 : ovf_q) | (!fst_i && sht_i && sh_lost) | add_ovf;
    end
  end

  // Accumulator and sticky overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/pe_shift_accum.sv
// NLANE-wide shift-and-accumulate stage between the Aunit array and PPAD.
// Define PE_SHACC_SAT_EN to clamp lanes on overflow instead of wrapping.
module pe_shift_accum
  import pe_shift_accum_pkg::*;
#(
  parameter int NLANE   = 16,
  parameter int AUODWD  = 16,
  parameter int PSUMDWD = 32,
  parameter int SHTWD   = SHACC_SHTWD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [NLANE*AUODWD-1:0]  i_data,
  input  logic                     i_fstpix,
  input  logic                     i_init,
  input  logic [NLANE*PSUMDWD-1:0] i_psum,
  input  logic                     i_sht,
  input  logic [SHTWD-1:0]         i_sht_num,
  input  logic                     i_sub,
  input  logic                     i_lstpix,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [NLANE*PSUMDWD-1:0] o_psum,
  output logic [NLANE-1:0]         o_ovf
);

  shacc_state_e state_q, state_d;
  ShAccOp       beat_op;
  logic         accept, eff_fst, eff_init;
  logic [PSUMDWD-1:0] lane_acc [NLANE];
  logic [NLANE-1:0]   lane_ovf;

  assign beat_op = '{fstpix:  i_fstpix,
                     init:    i_init,
                     sht:     i_sht,
                     sht_num: SHACC_SHTWD'(i_sht_num),
                     sub:     i_sub,
                     lstpix:  i_lstpix};

  assign o_valid = (state_q == ST_HOLD);
  assign i_ready = !o_valid || o_ready;
  assign accept  = i_valid && i_ready;
  // Any beat that does not continue an open psum starts a fresh one from zero.
  assign eff_fst  = beat_op.fstpix || (state_q != ST_ACC);
  assign eff_init = beat_op.fstpix && beat_op.init;

  // Next-state logic for the one-deep result holding FSM.
  always_comb begin
    state_d = state_q;
    if (accept)                             state_d = beat_op.lstpix ? ST_HOLD : ST_ACC;
    else if (state_q == ST_HOLD && o_ready) state_d = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    pe_shift_accum_lane #(
      .AUODWD  (AUODWD),
      .PSUMDWD (PSUMDWD)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .en_i      (accept),
      .fst_i     (eff_fst),
      .init_i    (eff_init),
      .sht_i     (beat_op.sht),
      .sht_num_i (beat_op.sht_num),
      .sub_i     (beat_op.sub),
      .data_i    (i_data[k*AUODWD +: AUODWD]),
      .psum_i    (i_psum[k*PSUMDWD +: PSUMDWD]),
      .acc_o     (lane_acc[k]),
      .ovf_o     (lane_ovf[k])
    );
  end

  // Pack lane accumulators onto the result bus; acc only moves on accepted beats,
  // so it stays stable while a result is held.
  always_comb begin
    o_psum = '0;
    for (int unsigned k = 0; k < NLANE; k++) o_psum[k*PSUMDWD +: PSUMDWD] = lane_acc[k];
    o_ovf = lane_ovf;
  end

endmodule

// File: tb/tb_pe_shift_accum.sv
module tb_pe_shift_accum;
  localparam int NLANE   = 16;
  localparam int AUODWD  = 16;
  localparam int PSUMDWD = 32;
  localparam int SHTWD   = 3;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst;
  logic i_valid, i_ready, i_fstpix, i_init, i_sht, i_sub, i_lstpix;
  logic [NLANE*AUODWD-1:0]  i_data;
  logic [NLANE*PSUMDWD-1:0] i_psum;
  logic [SHTWD-1:0]         i_sht_num;
  logic o_valid, o_ready;
  logic [NLANE*PSUMDWD-1:0] o_psum;
  logic [NLANE-1:0]         o_ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_shift_accum #(
    .NLANE(NLANE), .AUODWD(AUODWD), .PSUMDWD(PSUMDWD), .SHTWD(SHTWD)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .i_fstpix(i_fstpix), .i_init(i_init), .i_psum(i_psum), .i_sht(i_sht),
    .i_sht_num(i_sht_num), .i_sub(i_sub), .i_lstpix(i_lstpix), .o_valid(o_valid),
    .o_ready(o_ready), .o_psum(o_psum), .o_ovf(o_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit fst, input bit init, input bit sht, input logic [2:0] shn,
                      input bit sub, input bit lst, input logic [15:0] d, input logic [31:0] p);
    i_valid = 1'b1; i_fstpix = fst; i_init = init; i_sht = sht; i_sht_num = shn;
    i_sub = sub; i_lstpix = lst;
    i_data = {NLANE{d}};
    i_psum = {NLANE{p}};
  endtask

  task automatic idle();
    i_valid = 1'b0; i_fstpix = 1'b0; i_init = 1'b0; i_sht = 1'b0; i_sht_num = '0;
    i_sub = 1'b0; i_lstpix = 1'b0; i_data = '0; i_psum = '0;
  endtask

  task automatic chk_res(input string tag, input logic [31:0] exp_psum, input logic [15:0] exp_ovf);
    check({tag, ".valid"}, 32'(o_valid), 32'd1);
    check({tag, ".lane0"}, o_psum[31:0], exp_psum);
    check({tag, ".lastlane"}, o_psum[NLANE*PSUMDWD-1 -: PSUMDWD], exp_psum);
    check({tag, ".ovf"}, 32'(o_ovf), 32'(exp_ovf));
  endtask

  function automatic longint wrap32(input longint v);
    logic [31:0] t;
    t = 32'(v);
    return longint'($signed(t));
  endfunction

  // Reference lane: exact wide-integer arithmetic, then range checks.
  function automatic void lane_model(input longint acc, input bit ovf, input bit fst, input bit init,
                                     input bit sht, input int shn, input bit sub, input longint d,
                                     input longint seed, output longint nacc, output bit novf);
    longint base, sum;
    bit lost, aov;
    int s;
    lost = 1'b0;
    if (fst) base = init ? seed : 0;
    else if (sht) begin
      s = 1 << shn;
      if (s >= 32) begin
        lost = (acc != 0);
        base = 0;
      end else begin
        base = acc * (longint'(1) << s);
        lost = (base > MAXV) || (base < MINV);
        base = wrap32(base);
      end
`ifdef PE_SHACC_SAT_EN
      if (lost) base = (acc < 0) ? MINV : MAXV;
`endif
    end else base = acc;
    sum = sub ? base - d : base + d;
    aov = (sum > MAXV) || (sum < MINV);
`ifdef PE_SHACC_SAT_EN
    nacc = aov ? ((sum < 0) ? MINV : MAXV) : sum;
`else
    nacc = wrap32(sum);
`endif
    novf = (fst ? 1'b0 : ovf) | lost | aov;
  endfunction

  int     mstate;
  longint macc [NLANE];
  bit     movf [NLANE];
  bit     exp_rdy, acc_b;

  initial begin
    rst = 1'b1;
    o_ready = 1'b1;
    idle();
    repeat (2) tick();
    check("rst.valid", 32'(o_valid), 32'd0);
    check("rst.psum", o_psum[31:0], 32'd0);
    check("rst.ovf", 32'(o_ovf), 32'd0);
    check("rst.ready", 32'(i_ready), 32'd1);
    rst = 1'b0;

    // Reset mid-psum, then a non-first beat must start clean (and ignore i_sht).
    beat(1,0,0,0,0,0,16'd5,0); tick();
    beat(0,0,1,0,0,0,16'd1,0); tick();
    idle();
    rst = 1'b1; #1;
    check("rstmid.valid", 32'(o_valid), 32'd0);
    check("rstmid.psum", o_psum[31:0], 32'd0);
    check("rstmid.ovf", 32'(o_ovf), 32'd0);
    check("rstmid.ready", 32'(i_ready), 32'd1);
    #1 rst = 1'b0;
    beat(0,0,1,1,0,1,16'd2,0); tick(); idle();
    chk_res("rstclean", 32'd2, 16'h0000);
    tick();
    check("rstclean.drain", 32'(o_valid), 32'd0);

    // 0b1011 * 3, MSB first.
    beat(1,0,0,0,0,0,16'd3,0); tick();
    beat(0,0,1,0,0,0,16'd0,0); tick();
    beat(0,0,1,0,0,0,16'd3,0); tick();
    check("serial.pre", 32'(o_valid), 32'd0);
    beat(0,0,1,0,0,1,16'd3,0); tick(); idle();
    chk_res("serial", 32'd33, 16'h0000);
    tick();
    check("serial.drain", 32'(o_valid), 32'd0);

    // Signed MSB plane.
    beat(1,0,0,0,1,0,16'd5,0); tick();
    beat(0,0,1,0,0,1,16'd3,0); tick(); idle();
    chk_res("signed", 32'hFFFF_FFF9, 16'h0000);
    tick();
    beat(1,1,0,0,1,0,16'd10,32'd100); tick();
    beat(0,0,0,0,0,1,16'd3,0); tick(); idle();
    chk_res("seeded", 32'd93, 16'h0000);
    tick();

    // Backpressure, then drain and accept a first beat in the same cycle.
    o_ready = 1'b0;
    beat(1,0,0,0,0,1,16'd7,0); tick();
    beat(1,0,0,0,0,0,16'd9,0);
    for (int i = 0; i < 5; i++) begin
      check("bp.ready", 32'(i_ready), 32'd0);
      chk_res("bp.hold", 32'd7, 16'h0000);
      tick();
    end
    o_ready = 1'b1; #1;
    check("bp.release", 32'(i_ready), 32'd1);
    tick();
    check("bp.drained", 32'(o_valid), 32'd0);
    beat(0,0,0,0,0,1,16'd1,0); tick(); idle();
    chk_res("bp.next", 32'd10, 16'h0000);
    tick();

    // Overflow cases.
    beat(1,1,0,0,0,0,16'd0,32'h4000_0000); tick();
    beat(0,0,1,2,0,1,16'd0,0); tick(); idle();
`ifdef PE_SHACC_SAT_EN
    chk_res("ovf.shift", 32'h7FFF_FFFF, 16'hFFFF);
`else
    chk_res("ovf.shift", 32'h0000_0000, 16'hFFFF);
`endif
    beat(1,0,0,0,0,1,16'd1,0); tick(); idle();
    chk_res("ovf.clear", 32'd1, 16'h0000);
    beat(1,1,0,0,0,0,16'd0,32'd3); tick();
    beat(0,0,1,5,0,1,16'd4,0); tick(); idle();
`ifdef PE_SHACC_SAT_EN
    chk_res("ovf.sh32", 32'h7FFF_FFFF, 16'hFFFF);
`else
    chk_res("ovf.sh32", 32'd4, 16'hFFFF);
`endif
    beat(1,1,0,0,0,1,16'd1,32'h7FFF_FFFF); tick(); idle();
`ifdef PE_SHACC_SAT_EN
    chk_res("ovf.addpos", 32'h7FFF_FFFF, 16'hFFFF);
`else
    chk_res("ovf.addpos", 32'h8000_0000, 16'hFFFF);
`endif
    beat(1,1,0,0,1,1,16'd1,32'h8000_0000); tick(); idle();
`ifdef PE_SHACC_SAT_EN
    chk_res("ovf.subneg", 32'h8000_0000, 16'hFFFF);
`else
    chk_res("ovf.subneg", 32'h7FFF_FFFF, 16'hFFFF);
`endif
    beat(1,1,0,0,0,0,16'd1,32'h7FFF_FFFF); tick();
    beat(0,0,0,0,1,1,16'd1,0); tick(); idle();
`ifdef PE_SHACC_SAT_EN
    chk_res("ovf.sticky", 32'h7FFF_FFFE, 16'hFFFF);
`else
    chk_res("ovf.sticky", 32'h7FFF_FFFF, 16'hFFFF);
`endif
    beat(1,1,0,0,0,0,16'd0,32'hC000_0000); tick();
    beat(0,0,1,0,0,1,16'd0,0); tick(); idle();
    chk_res("ovf.edge", 32'h8000_0000, 16'h0000);
    tick();
    check("ovf.drain", 32'(o_valid), 32'd0);

    // Random streams against the reference model.
    mstate = 0;
    for (int k = 0; k < NLANE; k++) begin
      macc[k] = 0;
      movf[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      i_valid   = ($urandom_range(3) != 0);
      i_fstpix  = ($urandom_range(4) == 0);
      i_init    = 1'($urandom_range(1));
      i_sht     = ($urandom_range(9) < 6);
      i_sht_num = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : 3'($urandom_range(2));
      i_sub     = ($urandom_range(4) == 0);
      i_lstpix  = ($urandom_range(3) == 0);
      for (int k = 0; k < NLANE; k++) begin
        i_data[k*AUODWD +: AUODWD] = 16'($urandom);
        i_psum[k*PSUMDWD +: PSUMDWD] = ($urandom_range(1) == 0) ? 32'($urandom)
                                     : 32'($signed(20'($urandom)));
      end
      o_ready = ($urandom_range(9) < 7);
      #1;
      exp_rdy = (mstate != 2) || o_ready;
      check("rnd.ready", 32'(i_ready), 32'(exp_rdy));
      acc_b = i_valid && exp_rdy;
      if (acc_b) begin
        for (int k = 0; k < NLANE; k++)
          lane_model(macc[k], movf[k], i_fstpix || (mstate != 1), i_fstpix && i_init, i_sht,
                     int'(i_sht_num), i_sub, longint'($signed(i_data[k*AUODWD +: AUODWD])),
                     longint'($signed(i_psum[k*PSUMDWD +: PSUMDWD])), macc[k], movf[k]);
        mstate = i_lstpix ? 2 : 1;
      end else if (mstate == 2 && o_ready) begin
        mstate = 0;
      end
      @(posedge clk); #1;
      check("rnd.valid", 32'(o_valid), 32'(mstate == 2));
      if (mstate == 2) begin
        for (int k = 0; k < NLANE; k++) begin
          check("rnd.psum", o_psum[k*PSUMDWD +: PSUMDWD], 32'(macc[k]));
          check("rnd.ovf", 32'(o_ovf[k]), 32'(movf[k]));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
